// File: rtl/enemy_pkg.sv
// Shared types, constants and helpers for the enemy swarm engine.
package enemy_pkg;
    typedef enum logic [1:0] {
        DIR_R = 2'd0,
        DIR_L = 2'd1,
        DIR_D = 2'd2,
        DIR_U = 2'd3
    } dir_t;

    typedef struct packed {
        logic              active;
        dir_t              dir;
        logic signed [11:0] x;
        logic signed [11:0] y;
        logic [3:0]        speed;
    } slot_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int ADDR_W = 9;
    localparam int POS_W  = 12;

    function automatic int slot_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction
endpackage

// File: rtl/enemy_slot.sv
// One enemy slot: motion/spawn/kill state plus the stage-0 footprint test for the current pixel.
module enemy_slot
    import enemy_pkg::*;
#(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int SPR_LEN = 48,
    parameter int SPR_WID = 8
) (
    input  logic                    pixel_clk,
    input  logic                    rst_n,
    input  logic                    step,
    input  logic                    spawn,
    input  dir_t                    sp_dir,
    input  logic signed [POS_W-1:0] sp_x,
    input  logic signed [POS_W-1:0] sp_y,
    input  logic [3:0]              sp_speed,
    input  logic                    kill,
    input  logic [10:0]             draw_x,
    input  logic [10:0]             draw_y,
    output slot_t                   slot,
    output logic                    hit,
    output logic [ADDR_W-1:0]       addr
);
    localparam logic signed [POS_W-1:0] X_MAX   = POS_W'(H_RES);
    localparam logic signed [POS_W-1:0] Y_MAX   = POS_W'(V_RES);
    localparam logic signed [POS_W-1:0] NEG_LEN = POS_W'(-SPR_LEN);
    localparam logic [ADDR_W-1:0] A_LEN = ADDR_W'(SPR_LEN);
    localparam logic [ADDR_W-1:0] A_LM1 = ADDR_W'(SPR_LEN - 1);

    slot_t slot_q, slot_d;
    logic signed [POS_W-1:0] nx, ny, spd;
    logic gone;

    always_comb begin
        spd  = {{(POS_W-4){1'b0}}, slot_q.speed};
        nx   = slot_q.x;
        ny   = slot_q.y;
        gone = 1'b0;
        case (slot_q.dir)
            DIR_R:   begin nx = slot_q.x + spd; gone = (nx >= X_MAX);   end
            DIR_L:   begin nx = slot_q.x - spd; gone = (nx <= NEG_LEN); end
            DIR_D:   begin ny = slot_q.y + spd; gone = (ny >= Y_MAX);   end
            default: begin ny = slot_q.y - spd; gone = (ny <= NEG_LEN); end
        endcase

        // Spawn only targets an inactive slot, so kill on it is moot; kill beats move.
        slot_d = slot_q;
        if (spawn) begin
            slot_d.active = 1'b1;
            slot_d.dir    = sp_dir;
            slot_d.x      = sp_x;
            slot_d.y      = sp_y;
            slot_d.speed  = sp_speed;
        end else if (kill) begin
            slot_d.active = 1'b0;
        end else if (step && slot_q.active) begin
            slot_d.x      = nx;
            slot_d.y      = ny;
            slot_d.active = !gone;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) slot_q <= '0;
        else        slot_q <= slot_d;
    end

    assign slot = slot_q;

    logic signed [POS_W:0] dx, dy;
    logic in_rl, in_du;
    logic [ADDR_W-1:0] ax, ay, a;

    always_comb begin
        dx    = {2'b00, draw_x} - {slot_q.x[POS_W-1], slot_q.x};
        dy    = {2'b00, draw_y} - {slot_q.y[POS_W-1], slot_q.y};
        in_rl = !dx[POS_W] && (dx[POS_W-1:0] < POS_W'(SPR_LEN)) &&
                !dy[POS_W] && (dy[POS_W-1:0] < POS_W'(SPR_WID));
        in_du = !dx[POS_W] && (dx[POS_W-1:0] < POS_W'(SPR_WID)) &&
                !dy[POS_W] && (dy[POS_W-1:0] < POS_W'(SPR_LEN));
        ax    = ADDR_W'(dx);
        ay    = ADDR_W'(dy);
        case (slot_q.dir)
            DIR_R:   a = ax + A_LEN * ay;
            DIR_L:   a = (A_LM1 - ax) + A_LEN * ay;
            DIR_D:   a = ay + A_LEN * ax;
            default: a = (A_LM1 - ay) + A_LEN * ax;
        endcase
        hit  = slot_q.active && (slot_q.dir[1] ? in_du : in_rl);
        addr = hit ? a : '0;
    end
endmodule

// File: rtl/enemy_swarm.sv
// Enemy swarm top: spawn arbiter, cooldown, LFSR, per-slot instances and 2-stage render pipeline.
module enemy_swarm
    import enemy_pkg::*;
#(
    parameter int          N_ENEMY     = 4,
    parameter int          H_RES       = 640,
    parameter int          V_RES       = 480,
    parameter int          SPR_LEN     = 48,
    parameter int          SPR_WID     = 8,
    parameter int          BASE_SPEED  = 3,
    parameter int          SPAWN_GAP   = 30,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter logic [11:0] TRANSPARENT = 12'h000
) (
    input  logic                              pixel_clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic                              frame_tick,
    input  logic [10:0]                       drawX,
    input  logic [10:0]                       drawY,
    input  logic [1:0]                        speed_level,
    input  logic [N_ENEMY-1:0]                kill_mask,
    input  logic [11:0]                       rom_data,
    output logic [ADDR_W-1:0]                 rom_addr,
    output logic [11:0]                       enemy_color,
    output logic                              enemy_hit,
    output logic [slot_idx_w(N_ENEMY)-1:0]    hit_slot,
    output logic [N_ENEMY-1:0]                active_mask
);
    localparam int SLOT_W = slot_idx_w(N_ENEMY);
    localparam int LIM_RL = V_RES - SPR_WID;
    localparam int LIM_DU = H_RES - SPR_WID;
    localparam int CD_W   = $clog2(SPAWN_GAP + 1);
    localparam logic [9:0] MSK_RL = 10'((1 << $clog2(LIM_RL)) - 1);
    localparam logic [9:0] MSK_DU = 10'((1 << $clog2(LIM_DU)) - 1);
    localparam logic signed [POS_W-1:0] X_MAX   = POS_W'(H_RES);
    localparam logic signed [POS_W-1:0] Y_MAX   = POS_W'(V_RES);
    localparam logic signed [POS_W-1:0] NEG_LEN = POS_W'(-SPR_LEN);

    logic                               step, do_spawn;
    logic [15:0]                        lfsr_q, lfsr_d;
    logic [CD_W-1:0]                    cool_q, cool_d;
    logic [N_ENEMY-1:0]                 free_oh, spawn_vec;
    dir_t                               sp_dir;
    logic signed [POS_W-1:0]            sp_x, sp_y;
    logic [3:0]                         sp_speed;
    logic [4:0]                         spd_sum;
    logic [9:0]                         lane_raw, lane_lim, lane;
    slot_t [N_ENEMY-1:0]                slots;
    logic [N_ENEMY-1:0]                 slot_hit;
    logic [N_ENEMY-1:0][ADDR_W-1:0]     slot_addr;
    logic                               slot_fields_unused;

    assign step = frame_tick && en;

    always_comb begin
        // Lowest zero bit of the live mask is the spawn target.
        free_oh   = ~active_mask & (active_mask + 1'b1);
        do_spawn  = step && (cool_q == '0) && (|free_oh);
        spawn_vec = do_spawn ? free_oh : '0;

        sp_dir   = dir_t'(lfsr_q[1:0]);
        spd_sum  = 5'(BASE_SPEED) + 5'(speed_level) + 5'(lfsr_q[3:2]);
        sp_speed = (spd_sum > 5'd15) ? 4'hF : spd_sum[3:0];
        if (!lfsr_q[1]) begin
            lane_raw = lfsr_q[15:6] & MSK_RL;
            lane_lim = 10'(LIM_RL);
        end else begin
            lane_raw = lfsr_q[15:6] & MSK_DU;
            lane_lim = 10'(LIM_DU);
        end
        lane = (lane_raw >= lane_lim) ? lane_raw - lane_lim : lane_raw;
        sp_x = POS_W'(lane);
        sp_y = POS_W'(lane);
        case (sp_dir)
            DIR_R:   sp_x = NEG_LEN;
            DIR_L:   sp_x = X_MAX;
            DIR_D:   sp_y = NEG_LEN;
            default: sp_y = Y_MAX;
        endcase

        lfsr_d = lfsr_q;
        cool_d = cool_q;
        if (step) begin
            lfsr_d = lfsr_step(lfsr_q);
            if (do_spawn)          cool_d = CD_W'(SPAWN_GAP);
            else if (cool_q != '0) cool_d = cool_q - 1'b1;
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
            cool_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            cool_q <= cool_d;
        end
    end

    for (genvar g = 0; g < N_ENEMY; g++) begin : g_slot
        enemy_slot #(
            .H_RES(H_RES), .V_RES(V_RES), .SPR_LEN(SPR_LEN), .SPR_WID(SPR_WID)
        ) u_slot (
            .pixel_clk (pixel_clk),
            .rst_n     (rst_n),
            .step      (step),
            .spawn     (spawn_vec[g]),
            .sp_dir    (sp_dir),
            .sp_x      (sp_x),
            .sp_y      (sp_y),
            .sp_speed  (sp_speed),
            .kill      (kill_mask[g]),
            .draw_x    (drawX),
            .draw_y    (drawY),
            .slot      (slots[g]),
            .hit       (slot_hit[g]),
            .addr      (slot_addr[g])
        );
        assign active_mask[g] = slots[g].active;
    end

    assign slot_fields_unused = ^slots;

    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              hit1_q, hit1_d, hit2_q, hit2_d;
    logic [SLOT_W-1:0] slot1_q, slot1_d, slot2_q, slot2_d;

    always_comb begin
        rom_addr_d = '0;
        hit1_d     = 1'b0;
        slot1_d    = '0;
        for (int i = N_ENEMY - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                rom_addr_d = slot_addr[i];
                hit1_d     = 1'b1;
                slot1_d    = SLOT_W'(i);
            end
        end
        hit2_d  = hit1_q;
        slot2_d = slot1_q;
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q <= '0;
            hit1_q     <= 1'b0;
            slot1_q    <= '0;
            hit2_q     <= 1'b0;
            slot2_q    <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
            hit1_q     <= hit1_d;
            slot1_q    <= slot1_d;
            hit2_q     <= hit2_d;
            slot2_q    <= slot2_d;
        end
    end

    // Stage 2 lines up with the synchronous ROM read of rom_addr_q.
    assign rom_addr    = rom_addr_q;
    assign enemy_hit   = hit2_q && (rom_data != TRANSPARENT);
    assign enemy_color = enemy_hit ? rom_data : 12'h000;
    assign hit_slot    = slot2_q;
endmodule

// File: tb/tb_enemy_swarm.sv
// Self-checking bench for enemy_swarm: directed vectors plus randomized play against a behavioural model.
module tb_enemy_swarm;
    localparam int N = 4;

    logic          pixel_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          frame_tick = 1'b0;
    logic [10:0]   drawX = '0, drawY = '0;
    logic [1:0]    speed_level = '0;
    logic [N-1:0]  kill_mask = '0;
    logic [11:0]   rom_data;
    logic [8:0]    rom_addr;
    logic [11:0]   enemy_color;
    logic          enemy_hit;
    logic [1:0]    hit_slot;
    logic [N-1:0]  active_mask;

    int checks = 0;
    int errors = 0;

    enemy_swarm u_dut (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .en(en), .frame_tick(frame_tick),
        .drawX(drawX), .drawY(drawY), .speed_level(speed_level), .kill_mask(kill_mask),
        .rom_data(rom_data), .rom_addr(rom_addr), .enemy_color(enemy_color),
        .enemy_hit(enemy_hit), .hit_slot(hit_slot), .active_mask(active_mask)
    );

    always #5 pixel_clk = ~pixel_clk;

    function automatic logic [11:0] romf(input int a);
        if (a % 5 == 0) return 12'h000;
        return 12'((a * 37 + 5) | 1);
    endfunction

    always @(posedge pixel_clk) rom_data <= romf(int'(rom_addr));

    // Behavioural model of the swarm
    bit          m_act [N];
    int          m_dir [N], m_x [N], m_y [N], m_spd [N];
    int          m_cool;
    logic [15:0] m_lfsr;
    int          e_addr, e_hit1, e_slot1, e_hit2, e_slot2, e_rdaddr;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_dir[i] = 0; m_x[i] = 0; m_y[i] = 0; m_spd[i] = 0;
        end
        m_cool = 0; m_lfsr = 16'hACE1;
        e_addr = 0; e_hit1 = 0; e_slot1 = 0; e_hit2 = 0; e_slot2 = 0; e_rdaddr = 0;
    endtask

    function automatic int m_mask();
        int m = 0;
        for (int i = 0; i < N; i++) if (m_act[i]) m += (1 << i);
        return m;
    endfunction

    task automatic model_render(input int px, input int py, output int h, output int s, output int a);
        h = 0; s = 0; a = 0;
        for (int i = N - 1; i >= 0; i--) begin
            int dx, dy, len_x, len_y;
            dx = px - m_x[i];
            dy = py - m_y[i];
            len_x = (m_dir[i] < 2) ? 48 : 8;
            len_y = (m_dir[i] < 2) ? 8 : 48;
            if (m_act[i] && dx >= 0 && dx < len_x && dy >= 0 && dy < len_y) begin
                h = 1; s = i;
                case (m_dir[i])
                    0: a = dx + 48 * dy;
                    1: a = (47 - dx) + 48 * dy;
                    2: a = dy + 48 * dx;
                    default: a = (47 - dy) + 48 * dx;
                endcase
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: advance the model from the pre-edge inputs, then compare all outputs.
    task automatic cycle();
        int nh, ns, na, fr, l, d, s, lim, lane, exp_h;
        bit stp, spn;
        model_render(int'(drawX), int'(drawY), nh, ns, na);
        stp = frame_tick && en;
        fr = -1;
        for (int i = N - 1; i >= 0; i--) if (!m_act[i]) fr = i;
        spn = stp && (m_cool == 0) && (fr >= 0);
        for (int i = 0; i < N; i++) begin
            if (spn && i == fr) begin
                l = int'(m_lfsr);
                d = l % 4;
                s = 3 + int'(speed_level) + ((l / 4) % 4);
                if (s > 15) s = 15;
                lim  = (d < 2) ? 480 - 8 : 640 - 8;
                lane = (l / 64) % (1 << $clog2(lim));
                if (lane >= lim) lane -= lim;
                m_act[i] = 1; m_dir[i] = d; m_spd[i] = s;
                case (d)
                    0: begin m_x[i] = -48;  m_y[i] = lane; end
                    1: begin m_x[i] = 640;  m_y[i] = lane; end
                    2: begin m_x[i] = lane; m_y[i] = -48;  end
                    default: begin m_x[i] = lane; m_y[i] = 480; end
                endcase
            end else if (kill_mask[i]) begin
                m_act[i] = 0;
            end else if (stp && m_act[i]) begin
                case (m_dir[i])
                    0: begin m_x[i] += m_spd[i]; if (m_x[i] >= 640) m_act[i] = 0; end
                    1: begin m_x[i] -= m_spd[i]; if (m_x[i] <= -48) m_act[i] = 0; end
                    2: begin m_y[i] += m_spd[i]; if (m_y[i] >= 480) m_act[i] = 0; end
                    default: begin m_y[i] -= m_spd[i]; if (m_y[i] <= -48) m_act[i] = 0; end
                endcase
            end
        end
        if (stp) begin
            m_cool = spn ? 30 : ((m_cool > 0) ? m_cool - 1 : 0);
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        end
        @(posedge pixel_clk);
        e_hit2 = e_hit1; e_slot2 = e_slot1; e_rdaddr = e_addr;
        e_addr = na; e_hit1 = nh; e_slot1 = ns;
        #1;
        exp_h = (e_hit2 != 0) && (romf(e_rdaddr) != 12'h000);
        chk("rom_addr", int'(rom_addr), e_addr);
        chk("active_mask", int'(active_mask), m_mask());
        chk("enemy_hit", int'(enemy_hit), exp_h);
        chk("enemy_color", int'(enemy_color), exp_h ? int'(romf(e_rdaddr)) : 0);
        if (e_hit2 != 0) chk("hit_slot", int'(hit_slot), e_slot2);
    endtask

    task automatic pick_pixel();
        int j, px, py;
        j = $urandom_range(0, N - 1);
        if (m_act[j] && ($urandom_range(0, 3) != 0)) begin
            px = m_x[j] + $urandom_range(0, 60) - 6;
            py = m_y[j] + $urandom_range(0, 60) - 6;
        end else begin
            px = $urandom_range(0, 700);
            py = $urandom_range(0, 520);
        end
        if (px < 0) px = 0;
        if (py < 0) py = 0;
        drawX = 11'(px);
        drawY = 11'(py);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_rom_addr"}, int'(rom_addr), 0);
        chk({tag, "_enemy_color"}, int'(enemy_color), 0);
        chk({tag, "_enemy_hit"}, int'(enemy_hit), 0);
        chk({tag, "_hit_slot"}, int'(hit_slot), 0);
        chk({tag, "_active_mask"}, int'(active_mask), 0);
    endtask

    typedef struct {
        int px;
        int py;
        int addr;
        int hit;
    } vec_t;

    vec_t tbl [8];

    initial begin
        // Slot0 is L at x=640, y=179 after the first tick.
        tbl[0] = '{640, 179, 47, 1};
        tbl[1] = '{687, 186, 336, 1};
        tbl[2] = '{650, 180, 85, 1};
        tbl[3] = '{660, 183, 219, 1};
        tbl[4] = '{639, 179, 0, 0};
        tbl[5] = '{688, 179, 0, 0};
        tbl[6] = '{640, 187, 0, 0};
        tbl[7] = '{640, 178, 0, 0};

        model_reset();
        #1;
        check_cleared("reset");
        #11;
        rst_n = 1'b1;

        en = 1'b1; frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        chk("first_spawn_mask", int'(active_mask), 1);

        for (int k = 0; k < 8; k++) begin
            drawX = 11'(tbl[k].px);
            drawY = 11'(tbl[k].py);
            cycle();
            chk("tbl_rom_addr", int'(rom_addr), tbl[k].addr);
            cycle();
            chk("tbl_enemy_hit", int'(enemy_hit),
                int'(tbl[k].hit != 0 && romf(tbl[k].addr) != 12'h000));
        end

        // 180 ticks of L at speed 3 bring slot0 from 640 to 100.
        for (int k = 0; k < 360; k++) begin
            frame_tick = (k % 2 == 0);
            pick_pixel();
            cycle();
        end
        frame_tick = 1'b0;
        drawX = 11'd100; drawY = 11'd179;
        cycle();
        chk("slot0_at_100_addr", int'(rom_addr), 47);
        drawX = 11'd147; drawY = 11'd186;
        cycle();
        chk("slot0_far_corner_addr", int'(rom_addr), 336);

        en = 1'b0; frame_tick = 1'b1;
        drawX = 11'd100; drawY = 11'd179;
        for (int k = 0; k < 10; k++) cycle();
        chk("frozen_addr", int'(rom_addr), 47);
        en = 1'b1; frame_tick = 1'b0;
        cycle();

        kill_mask = 4'b0001; frame_tick = 1'b1;
        cycle();
        chk("kill_slot0", int'(active_mask[0]), 0);
        kill_mask = '0; frame_tick = 1'b0;
        cycle();

        for (int k = 0; k < 4000; k++) begin
            en          = ($urandom_range(0, 7) != 0);
            frame_tick  = ($urandom_range(0, 2) == 0);
            speed_level = 2'($urandom_range(0, 3));
            kill_mask   = ($urandom_range(0, 19) == 0) ? N'($urandom_range(0, 15)) : '0;
            pick_pixel();
            cycle();
        end
        kill_mask = '0; frame_tick = 1'b0; en = 1'b1; speed_level = '0;
        drawX = 11'd640; drawY = 11'd179;

        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("midreset");
        model_reset();
        #2;
        rst_n = 1'b1;

        frame_tick = 1'b1;
        cycle();
        frame_tick = 1'b0;
        chk("respawn_mask", int'(active_mask), 1);
        cycle();
        chk("respawn_addr", int'(rom_addr), 47);
        drawX = 11'd687; drawY = 11'd186;
        cycle();
        chk("respawn_corner_addr", int'(rom_addr), 336);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
